// File: rtl/dma_mem2mem_sequencer.sv
// Memory-to-memory DMA sequencer: read a word into the temp register,
// then write it out, advancing source/destination per word.
module dma_mem2mem_sequencer #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              src_dec,
   input  logic              src_hold,
   input  logic              dst_dec,
   input  logic              ready,
   output logic [ADDR_W-1:0] addr_out,
   output logic              memr_n,
   output logic              memw_n,
   output logic              temp_counts,
   output logic              busy,
   output logic              tc,
   output logic [CNT_W-1:0]  words_done
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      HOLD,
      WRITE,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_cur;
   logic [ADDR_W-1:0] dst_cur;
   logic [CNT_W-1:0]  remaining;
   logic              src_dec_q;
   logic              src_hold_q;
   logic              dst_dec_q;
   logic [ADDR_W-1:0] src_nxt;
   logic [ADDR_W-1:0] dst_nxt;

   // Next source/destination addresses, modulo 2^ADDR_W.
   always_comb begin
      src_nxt = src_cur;
      if (!src_hold_q) begin
         if (src_dec_q) src_nxt = src_cur - ADDR_W'(1);
         else           src_nxt = src_cur + ADDR_W'(1);
      end
      if (dst_dec_q) dst_nxt = dst_cur - ADDR_W'(1);
      else           dst_nxt = dst_cur + ADDR_W'(1);
   end

   // Sequencer FSM; each transition loads the outputs of the state it enters.
   always_ff @(posedge clk) begin
      tc <= 1'b0;
      if (reset) begin
         state       <= IDLE;
         src_cur     <= '0;
         dst_cur     <= '0;
         remaining   <= '0;
         src_dec_q   <= 1'b0;
         src_hold_q  <= 1'b0;
         dst_dec_q   <= 1'b0;
         addr_out    <= '0;
         memr_n      <= 1'b1;
         memw_n      <= 1'b1;
         temp_counts <= 1'b1;
         busy        <= 1'b0;
         words_done  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  src_cur    <= src_addr;
                  dst_cur    <= dst_addr;
                  remaining  <= word_count;
                  src_dec_q  <= src_dec;
                  src_hold_q <= src_hold;
                  dst_dec_q  <= dst_dec;
                  words_done <= '0;
                  busy       <= 1'b1;
                  if (word_count != '0) begin
                     state    <= READ;
                     addr_out <= src_addr;
                     memr_n   <= 1'b0;
                  end else begin
                     state <= DONE;
                     tc    <= 1'b1;
                  end
               end
            end
            READ: begin
               if (ready) begin
                  state       <= HOLD;
                  addr_out    <= dst_cur;
                  memr_n      <= 1'b1;
                  temp_counts <= 1'b0;
               end
            end
            HOLD: begin
               state  <= WRITE;
               memw_n <= 1'b0;
            end
            WRITE: begin
               if (ready) begin
                  memw_n      <= 1'b1;
                  temp_counts <= 1'b1;
                  words_done  <= words_done + CNT_W'(1);
                  remaining   <= remaining - CNT_W'(1);
                  src_cur     <= src_nxt;
                  dst_cur     <= dst_nxt;
                  if (remaining == CNT_W'(1)) begin
                     state <= DONE;
                     tc    <= 1'b1;
                  end else begin
                     state    <= READ;
                     addr_out <= src_nxt;
                     memr_n   <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               memr_n      <= 1'b1;
               memw_n      <= 1'b1;
               temp_counts <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_mem2mem_sequencer.sv
// Bench for dma_mem2mem_sequencer: memory + temp register environment,
// transfer-level reference model, directed and random transfers.
module tb_dma_mem2mem_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [15:0] word_count;
   logic        src_dec;
   logic        src_hold;
   logic        dst_dec;
   logic        ready;
   logic [15:0] addr_out;
   logic        memr_n;
   logic        memw_n;
   logic        temp_counts;
   logic        busy;
   logic        tc;
   logic [15:0] words_done;

   dma_mem2mem_sequencer #(.ADDR_W(16), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr),
      .word_count(word_count), .src_dec(src_dec),
      .src_hold(src_hold), .dst_dec(dst_dec),
      .ready(ready), .addr_out(addr_out),
      .memr_n(memr_n), .memw_n(memw_n),
      .temp_counts(temp_counts), .busy(busy),
      .tc(tc), .words_done(words_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  mem [0:65535];
   logic [7:0]  temp_reg;
   logic [15:0] rd_q[$];
   logic [15:0] wr_a[$];
   logic [7:0]  wr_d[$];
   int          waits;
   int          mode;
   int          rd_left;
   int          wr_left;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Environment: drives ready, models memory + temp register on each edge.
   initial begin
      ready = 1'b1;
      temp_reg = 8'h00;
      waits = 0;
      mode = 0;
      rd_left = 0;
      wr_left = 0;
      forever begin
         @(negedge clk);
         if (mode == 1) begin
            ready = ($urandom_range(0, 2) != 0);
         end else if (mode == 2) begin
            ready = 1'b1;
            if (!memr_n && rd_left > 0) begin
               ready = 1'b0;
               rd_left--;
            end
            if (!memw_n && wr_left > 0) begin
               ready = 1'b0;
               wr_left--;
            end
         end else begin
            ready = 1'b1;
         end
         chk("strobe_excl", {31'b0, memr_n | memw_n}, 32'd1);
         chk("temp_drive_vs_read",
             {31'b0, !temp_counts && !memr_n}, 32'd0);
         if ((!memr_n || !memw_n) && !ready) waits++;
         if (!memr_n && ready) begin
            temp_reg = mem[addr_out];
            rd_q.push_back(addr_out);
         end
         if (!memw_n && ready) begin
            mem[addr_out] = temp_reg;
            wr_a.push_back(addr_out);
            wr_d.push_back(temp_reg);
         end
      end
   end

   task automatic run_xfer(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] n, input logic sh,
                           input logic sd, input logic dd,
                           input int rmode, input int rw, input int ww,
                           input bit poke);
      logic [15:0] ea_r[$];
      logic [15:0] ea_w[$];
      logic [7:0]  ed[$];
      logic [7:0]  shadow[int];
      logic [15:0] sa;
      logic [15:0] da;
      logic [7:0]  v;
      int          cyc;
      sa = s;
      da = d;
      for (int i = 0; i < int'(n); i++) begin
         v = shadow.exists(int'(sa)) ? shadow[int'(sa)] : mem[sa];
         ea_r.push_back(sa);
         ea_w.push_back(da);
         ed.push_back(v);
         shadow[int'(da)] = v;
         if (!sh) sa = sd ? sa - 16'd1 : sa + 16'd1;
         da = dd ? da - 16'd1 : da + 16'd1;
      end
      rd_q.delete();
      wr_a.delete();
      wr_d.delete();
      @(negedge clk);
      waits = 0;
      mode = rmode;
      rd_left = rw;
      wr_left = ww;
      src_addr = s;
      dst_addr = d;
      word_count = n;
      src_hold = sh;
      src_dec = sd;
      dst_dec = dd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      src_addr = 16'($urandom);
      dst_addr = 16'($urandom);
      word_count = 16'($urandom);
      cyc = 1;
      while (!tc && cyc < 2000) begin
         if (poke && cyc == 3) begin
            start = 1'b1;
            src_addr = 16'($urandom);
            dst_addr = 16'($urandom);
            word_count = 16'($urandom_range(1, 5));
         end
         if (cyc == 4) start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("tc_time", cyc, 3 * int'(n) + waits + 1);
      chk("busy_in_done", {31'b0, busy}, 32'd1);
      chk("words_done", {16'b0, words_done}, {16'b0, n});
      mode = 0;
      @(negedge clk);
      chk("tc_one_cycle", {31'b0, tc}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_temp", {31'b0, temp_counts}, 32'd1);
      chk("n_reads", rd_q.size(), ea_r.size());
      chk("n_writes", wr_a.size(), ea_w.size());
      for (int i = 0; i < ea_r.size() && i < rd_q.size(); i++)
         chk("rd_addr", {16'b0, rd_q[i]}, {16'b0, ea_r[i]});
      for (int i = 0; i < ea_w.size() && i < wr_a.size(); i++) begin
         chk("wr_addr", {16'b0, wr_a[i]}, {16'b0, ea_w[i]});
         chk("wr_data", {24'b0, wr_d[i]}, {24'b0, ed[i]});
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      reset = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      word_count = '0;
      src_dec = 1'b0;
      src_hold = 1'b0;
      dst_dec = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_addr", {16'b0, addr_out}, 32'd0);
      chk("rst_memr", {31'b0, memr_n}, 32'd1);
      chk("rst_memw", {31'b0, memw_n}, 32'd1);
      chk("rst_temp", {31'b0, temp_counts}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_tc", {31'b0, tc}, 32'd0);
      chk("rst_wd", {16'b0, words_done}, 32'd0);
      reset = 1'b0;

      mem[16'h0100] = 8'h01;
      mem[16'h0101] = 8'hAF;
      mem[16'h0102] = 8'h5A;
      run_xfer(16'h0100, 16'h0200, 16'd3, 0, 0, 0, 0, 0, 0, 0);
      chk("basic_m0", {24'b0, mem[16'h0200]}, 32'h01);
      chk("basic_m1", {24'b0, mem[16'h0201]}, 32'hAF);
      chk("basic_m2", {24'b0, mem[16'h0202]}, 32'h5A);

      run_xfer(16'h0300, 16'h0400, 16'd1, 0, 0, 0, 2, 2, 3, 0);
      chk("wait_total", waits, 5);
      chk("wait_data", {24'b0, mem[16'h0400]}, {24'b0, mem[16'h0300]});

      mem[16'h0010] = 8'h77;
      run_xfer(16'h0010, 16'hFFFE, 16'd4, 1, 0, 0, 0, 0, 0, 0);
      chk("fill_fffe", {24'b0, mem[16'hFFFE]}, 32'h77);
      chk("fill_ffff", {24'b0, mem[16'hFFFF]}, 32'h77);
      chk("fill_0000", {24'b0, mem[16'h0000]}, 32'h77);
      chk("fill_0001", {24'b0, mem[16'h0001]}, 32'h77);

      run_xfer(16'h1234, 16'h4321, 16'd0, 0, 0, 0, 0, 0, 0, 0);
      run_xfer(16'h0500, 16'h0600, 16'd2, 0, 0, 0, 1, 0, 0, 1);
      run_xfer(16'h0003, 16'h0000, 16'd2, 0, 1, 1, 0, 0, 0, 0);

      // Reset in the middle of a write cycle.
      @(negedge clk);
      src_addr = 16'h0700;
      dst_addr = 16'h0800;
      word_count = 16'd3;
      src_hold = 1'b0;
      src_dec = 1'b0;
      dst_dec = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && memw_n; i++) @(negedge clk);
      chk("reached_write", {31'b0, memw_n}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_memw", {31'b0, memw_n}, 32'd1);
      chk("mid_rst_memr", {31'b0, memr_n}, 32'd1);
      chk("mid_rst_temp", {31'b0, temp_counts}, 32'd1);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_wd", {16'b0, words_done}, 32'd0);
      chk("mid_rst_tc", {31'b0, tc}, 32'd0);
      @(negedge clk);
      chk("mid_rst_no_tc", {31'b0, tc}, 32'd0);
      chk("mid_rst_idle", {31'b0, busy}, 32'd0);

      for (int t = 0; t < 12; t++) begin
         run_xfer(16'($urandom), 16'($urandom),
                  16'($urandom_range(0, 6)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 1)), 0, 0,
                  1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dma_mem2mem_sequencer.md
Name: dma_mem2mem_sequencer

Overview:
- Control stage directly upstream of the DMA temporary register. It sequences memory-to-memory transfers: a read cycle at the source address captures a bus word into the temporary register, then a write cycle drives that word to the destination address.
- Generates the addresses and the active-low memory strobes, and drives the temporary register's counts control (1 = capture from Data, 0 = drive Data).
- Repeats for the programmed word count, then pulses terminal count.

Parameters:
ADDR_W, 16, width of source/destination/address bus
CNT_W, 16, width of word count

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  request new transfer; sampled only in IDLE
src_addr  input  ADDR_W  first source address, latched on accepted start
dst_addr  input  ADDR_W  first destination address, latched on accepted start
word_count  input  CNT_W  number of words to move, latched on accepted start
src_dec  input  1  1 = source address decrements, 0 = increments (latched)
src_hold  input  1  1 = source address held constant (block fill), overrides src_dec (latched)
dst_dec  input  1  1 = destination address decrements (latched)
ready  input  1  memory ready; 0 extends current READ/WRITE cycle
addr_out  output  ADDR_W  memory address bus
memr_n  output  1  memory read strobe, active low
memw_n  output  1  memory write strobe, active low
temp_counts  output  1  to temporary register counts: 1 = capture bus, 0 = drive bus
busy  output  1  transfer in progress
tc  output  1  terminal count, one-cycle pulse
words_done  output  CNT_W  words completed in current/last transfer

Behaviour:
- Outputs are Moore-decoded from registered state and address registers; no input-to-output combinational path.
- Reset (synchronous, wins over everything incl. mid-transfer): state IDLE, addr_out=0, memr_n=1, memw_n=1, temp_counts=1, busy=0, tc=0, words_done=0. Internal src/dst/remaining registers cleared.
- States: IDLE, READ, HOLD, WRITE, DONE.
- IDLE: memr_n=1, memw_n=1, temp_counts=1 (temp never drives bus while idle), busy=0, addr_out holds last value.
  - start=1 and word_count!=0: latch all inputs, clear words_done, go to READ.
  - start=1 and word_count==0: latch, clear words_done, go to DONE; no bus cycles.
- READ: addr_out=src_cur, memr_n=0, memw_n=1, temp_counts=1, busy=1. Stays while ready=0. On the edge where ready=1, the temporary register captures Data; go to HOLD.
- HOLD: exactly 1 cycle; addr_out=dst_cur, both strobes 1, temp_counts=0. This edge loads the temporary register's output latch before the write strobe.
- WRITE: addr_out=dst_cur, memw_n=0, memr_n=1, temp_counts=0. Stays while ready=0. On the edge where ready=1:
  - words_done+1, remaining-1.
  - src_cur updates: hold, -1, or +1. dst_cur updates: -1 or +1.
  - If remaining was 1, go to DONE; else go to READ.
- DONE: 1 cycle; tc=1, busy=1, strobes 1, temp_counts=1; go to IDLE. tc is 0 in all other states.
- Minimum 3 cycles per word (READ, HOLD, WRITE); each ready=0 cycle in READ or WRITE adds 1.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000, 0x0000-1 wraps to 0xFFFF (ADDR_W=16). Count compares are on the full CNT_W; word_count=2^CNT_W-1 is legal.
- start while busy is ignored; it is not queued.
- memr_n and memw_n are never both 0. temp_counts=0 only in HOLD and WRITE.

Test Plan:
- Reset mid-WRITE: assert reset for 1 cycle -> next cycle IDLE; memw_n=1, temp_counts=1, busy=0, words_done=0; no tc.
- Basic 3-word increment: src=0x0100, dst=0x0200, count=3, ready=1, memory src={0x01,0xAF,0x5A} -> dst 0x0200..0x0202 = {0x01,0xAF,0x5A}; tc pulses exactly 9 cycles after the IDLE-exit cycle; words_done=3.
- Wait states: count=1, hold ready=0 for 2 cycles in READ and 3 cycles in WRITE -> strobes stretched by exactly those cycles; data written correctly; total 3+5 cycles before DONE.
- Block fill with wrap: src_hold=1, src=0x0010 (value 0x77), dst=0xFFFE, dst_dec=0, count=4 -> writes 0x77 to 0xFFFE, 0xFFFF, 0x0000, 0x0001; source address constant at 0x0010 in every READ.
- Zero count and start while busy: count=0 -> DONE the next cycle, tc=1 for 1 cycle, memr_n/memw_n never low. During a 2-word transfer, pulse start with new addresses -> ignored; original transfer completes unchanged.
- Decrement mode: src=0x0003, src_dec=1, dst=0x0000, dst_dec=1, count=2 -> reads 0x0003, 0x0002; writes 0x0000, 0xFFFF.
